// File: rtl/usb_ep0_ctrl.sv
// Endpoint-0 control-transfer sequencer: captures SETUP packets, decodes standard requests,
// and drives the core handshake/toggle/data strobes through the DATA and STATUS stages.
module usb_ep0_ctrl #(
  parameter int MAX_PKT  = 64,
  parameter int ROM_AW   = 8,
  parameter int DEV_BASE = 0,
  parameter int DEV_LEN  = 18,
  parameter int CFG_BASE = 18,
  parameter int CFG_LEN  = 9
) (
  input  logic              clk_48,
  input  logic              rst,
  input  logic              usb_rst,
  input  logic [3:0]        endpoint,
  input  logic              transaction_active,
  input  logic              direction_in,
  input  logic              setup,
  input  logic              data_strobe,
  input  logic              success,
  input  logic [7:0]        data_out,
  output logic [1:0]        handshake,
  output logic              data_toggle,
  output logic [7:0]        data_in,
  output logic              data_in_valid,
  output logic [6:0]        usb_address,
  output logic [7:0]        config_value,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SETUP_RX   = 3'd1;
  localparam logic [2:0] S_DECODE     = 3'd2;
  localparam logic [2:0] S_DATA_IN    = 3'd3;
  localparam logic [2:0] S_STATUS_OUT = 3'd4;
  localparam logic [2:0] S_STATUS_IN  = 3'd5;
  localparam logic [2:0] S_STALL      = 3'd6;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b10;
  localparam logic [1:0] HS_STALL = 2'b11;

  localparam logic [15:0]       MAX_PKT_W  = 16'(MAX_PKT);
  localparam logic [15:0]       DEV_LEN_W  = 16'(DEV_LEN);
  localparam logic [15:0]       CFG_LEN_W  = 16'(CFG_LEN);
  localparam logic [ROM_AW-1:0] DEV_BASE_A = ROM_AW'(DEV_BASE);
  localparam logic [ROM_AW-1:0] CFG_BASE_A = ROM_AW'(CFG_BASE);

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [2:0]        state_q, state_d;
  logic              ta_q, ta_d, ds_q, ds_d;
  logic [1:0]        hs_q, hs_d;
  logic              tog_q, tog_d;
  logic [7:0]        data_in_q, data_in_d;
  logic              valid_q, valid_d;
  logic [6:0]        addr_q, addr_d, pend_q, pend_d;
  logic [7:0]        cfg_q, cfg_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d, base_q, base_d;
  logic [7:0]        buf_q [0:7];
  logic [7:0]        buf_d [0:7];
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       offset_q, offset_d, remain_q, remain_d;
  logic [6:0]        idx_q, idx_d;
  logic              cur_ep0_q, cur_ep0_d, cur_in_q, cur_in_d;

  logic              ta_rise_s, ds_rise_s, ep0_s;
  logic [15:0]       pkt_s, wlen_s;

  assign ta_rise_s = transaction_active & ~ta_q;
  assign ds_rise_s = data_strobe & ~ds_q;
  assign ep0_s     = (endpoint == 4'd0);
  assign pkt_s     = min16(remain_q, MAX_PKT_W);
  assign wlen_s    = {buf_q[7], buf_q[6]};

  // Next-state and datapath logic for the control-transfer sequencer
  always_comb begin
    ta_d       = transaction_active;
    ds_d       = data_strobe;
    state_d    = state_q;
    hs_d       = hs_q;
    tog_d      = tog_q;
    data_in_d  = rom_data;
    valid_d    = valid_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    cfg_d      = cfg_q;
    rom_addr_d = rom_addr_q;
    base_d     = base_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    remain_d   = remain_q;
    idx_d      = idx_q;
    cur_ep0_d  = cur_ep0_q;
    cur_in_d   = cur_in_q;
    if (usb_rst) begin
      state_d    = S_IDLE;
      hs_d       = HS_ACK;
      tog_d      = 1'b0;
      data_in_d  = 8'd0;
      valid_d    = 1'b0;
      addr_d     = 7'd0;
      pend_d     = 7'd0;
      cfg_d      = 8'd0;
      rom_addr_d = '0;
      base_d     = '0;
      for (int i = 0; i < 8; i++) buf_d[i] = 8'd0;
      cnt_d      = 4'd0;
      offset_d   = 16'd0;
      remain_d   = 16'd0;
      idx_d      = 7'd0;
      cur_ep0_d  = 1'b0;
      cur_in_d   = 1'b0;
    end else begin
      if (ta_rise_s) begin
        cur_ep0_d = ep0_s;
        cur_in_d  = direction_in;
        if (!ep0_s) begin
          hs_d = HS_NAK;
        end else if (setup) begin
          state_d = S_SETUP_RX;
          cnt_d   = 4'd0;
          hs_d    = HS_ACK;
          tog_d   = 1'b0;
        end else begin
          if (direction_in) idx_d = 7'd0;
          else              idx_d = idx_q;
          case (state_q)
            S_STALL:      hs_d = HS_STALL;
            S_DATA_IN:    hs_d = HS_ACK;
            S_STATUS_OUT: hs_d = direction_in ? HS_NAK : HS_ACK;
            S_STATUS_IN:  hs_d = direction_in ? HS_ACK : HS_NAK;
            default:      hs_d = HS_NAK;
          endcase
        end
      end else begin
        case (state_q)
          S_SETUP_RX: begin
            if (cur_ep0_q && ds_rise_s) begin
              if (cnt_q == 4'd8) begin
                state_d = S_IDLE;
              end else begin
                buf_d[cnt_q[2:0]] = data_out;
                cnt_d             = cnt_q + 4'd1;
              end
            end else if (cur_ep0_q && success) begin
              state_d = (cnt_q == 4'd8) ? S_DECODE : S_IDLE;
            end else begin
              state_d = state_q;
            end
          end
          S_DECODE: begin
            case (buf_q[1])
              8'h05: begin
                pend_d  = buf_q[2][6:0];
                tog_d   = 1'b1;
                state_d = S_STATUS_IN;
              end
              8'h09: begin
                cfg_d   = buf_q[2];
                tog_d   = 1'b1;
                state_d = S_STATUS_IN;
              end
              8'h06: begin
                offset_d = 16'd0;
                idx_d    = 7'd0;
                tog_d    = 1'b1;
                if (buf_q[3] == 8'd1) begin
                  base_d   = DEV_BASE_A;
                  remain_d = min16(DEV_LEN_W, wlen_s);
                  state_d  = (remain_d == 16'd0) ? S_STATUS_OUT : S_DATA_IN;
                end else if (buf_q[3] == 8'd2) begin
                  base_d   = CFG_BASE_A;
                  remain_d = min16(CFG_LEN_W, wlen_s);
                  state_d  = (remain_d == 16'd0) ? S_STATUS_OUT : S_DATA_IN;
                end else begin
                  state_d = S_STALL;
                end
              end
              default: state_d = S_STALL;
            endcase
          end
          S_DATA_IN: begin
            // An ep0 OUT arriving here is the host cutting the data stage short.
            if (cur_ep0_q && cur_in_q) begin
              if (ds_rise_s && (16'(idx_q) < pkt_s)) begin
                idx_d = idx_q + 7'd1;
              end else if (success) begin
                offset_d = offset_q + pkt_s;
                remain_d = remain_q - pkt_s;
                if (remain_q == pkt_s) begin
                  state_d = S_STATUS_OUT;
                  tog_d   = 1'b1;
                end else begin
                  tog_d = ~tog_q;
                end
              end else begin
                idx_d = idx_q;
              end
            end else if (cur_ep0_q && success) begin
              state_d = S_IDLE;
            end else begin
              state_d = state_q;
            end
          end
          S_STATUS_OUT: begin
            if (cur_ep0_q && !cur_in_q && success) state_d = S_IDLE;
            else                                   state_d = state_q;
          end
          S_STATUS_IN: begin
            if (cur_ep0_q && cur_in_q && success) begin
              addr_d  = pend_q;
              state_d = S_IDLE;
            end else begin
              state_d = state_q;
            end
          end
          default: state_d = state_q;
        endcase
      end
      valid_d    = (state_d == S_DATA_IN) && (16'(idx_d) < min16(remain_d, MAX_PKT_W));
      rom_addr_d = base_d + offset_d[ROM_AW-1:0] + ROM_AW'(idx_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ta_q       <= 1'b0;
      ds_q       <= 1'b0;
      hs_q       <= HS_ACK;
      tog_q      <= 1'b0;
      data_in_q  <= 8'd0;
      valid_q    <= 1'b0;
      addr_q     <= 7'd0;
      pend_q     <= 7'd0;
      cfg_q      <= 8'd0;
      rom_addr_q <= '0;
      base_q     <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= 8'd0;
      cnt_q      <= 4'd0;
      offset_q   <= 16'd0;
      remain_q   <= 16'd0;
      idx_q      <= 7'd0;
      cur_ep0_q  <= 1'b0;
      cur_in_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ta_q       <= ta_d;
      ds_q       <= ds_d;
      hs_q       <= hs_d;
      tog_q      <= tog_d;
      data_in_q  <= data_in_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      cfg_q      <= cfg_d;
      rom_addr_q <= rom_addr_d;
      base_q     <= base_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      offset_q   <= offset_d;
      remain_q   <= remain_d;
      idx_q      <= idx_d;
      cur_ep0_q  <= cur_ep0_d;
      cur_in_q   <= cur_in_d;
    end
  end

  assign handshake     = hs_q;
  assign data_toggle   = tog_q;
  assign data_in       = data_in_q;
  assign data_in_valid = valid_q;
  assign usb_address   = addr_q;
  assign config_value  = cfg_q;
  assign rom_addr      = rom_addr_q;

endmodule

// File: tb/tb_usb_ep0_ctrl.sv
// Bench for usb_ep0_ctrl: emulates the core and host side of ep0 control transfers and
// checks them against a transfer-level model (expected bytes drawn straight from the ROM image).
module tb_usb_ep0_ctrl;

  localparam int MAX_PKT  = 8;
  localparam int ROM_AW   = 8;
  localparam int DEV_BASE = 0;
  localparam int DEV_LEN  = 18;
  localparam int CFG_BASE = 18;
  localparam int CFG_LEN  = 9;

  localparam int HS_ACK   = 0;
  localparam int HS_NAK   = 2;
  localparam int HS_STALL = 3;

  logic              clk_48 = 1'b0;
  logic              rst = 1'b1;
  logic              usb_rst = 1'b0;
  logic [3:0]        endpoint = 4'd0;
  logic              transaction_active = 1'b0;
  logic              direction_in = 1'b0;
  logic              setup = 1'b0;
  logic              data_strobe = 1'b0;
  logic              success = 1'b0;
  logic [7:0]        data_out = 8'd0;
  logic [1:0]        handshake;
  logic              data_toggle;
  logic [7:0]        data_in;
  logic              data_in_valid;
  logic [6:0]        usb_address;
  logic [7:0]        config_value;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;

  logic [7:0] rom [0:255];
  int n_vec = 0;
  int n_err = 0;
  int exp_addr = 0;
  int exp_cfg = 0;

  usb_ep0_ctrl #(
    .MAX_PKT(MAX_PKT), .ROM_AW(ROM_AW), .DEV_BASE(DEV_BASE), .DEV_LEN(DEV_LEN),
    .CFG_BASE(CFG_BASE), .CFG_LEN(CFG_LEN)
  ) dut (
    .clk_48(clk_48), .rst(rst), .usb_rst(usb_rst), .endpoint(endpoint),
    .transaction_active(transaction_active), .direction_in(direction_in), .setup(setup),
    .data_strobe(data_strobe), .success(success), .data_out(data_out),
    .handshake(handshake), .data_toggle(data_toggle), .data_in(data_in),
    .data_in_valid(data_in_valid), .usb_address(usb_address), .config_value(config_value),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #10 clk_48 = ~clk_48;

  always @(posedge clk_48) rom_data <= rom[rom_addr];

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_48);
  endtask

  function automatic logic [63:0] mk_setup(input logic [7:0] req, input logic [15:0] wval,
                                           input logic [15:0] wlen);
    return {wlen, 16'h0000, wval, req, 8'h80};
  endfunction

  task automatic txn_start(input logic [3:0] ep, input logic dir, input logic stp);
    endpoint = ep; direction_in = dir; setup = stp; transaction_active = 1'b1;
    tick(4);
  endtask

  task automatic txn_end(input logic ok);
    success = ok;
    tick(1);
    success = 1'b0; transaction_active = 1'b0; setup = 1'b0;
    tick(2);
  endtask

  task automatic strobe();
    data_strobe = 1'b1;
    tick(1);
    data_strobe = 1'b0;
    tick(3);
  endtask

  task automatic send_setup(input logic [63:0] v, input int n, input logic ok);
    txn_start(4'd0, 1'b0, 1'b1);
    check_val("setup_hs", handshake, HS_ACK);
    for (int i = 0; i < n; i++) begin
      data_out = (i < 8) ? v[8*i +: 8] : 8'hA5;
      strobe();
    end
    txn_end(ok);
  endtask

  task automatic do_hs(input string tag, input logic [3:0] ep, input logic dir,
                       input int exp_hs, input logic ok);
    txn_start(ep, dir, 1'b0);
    check_val({tag, "_hs"}, handshake, exp_hs);
    txn_end(ok);
  endtask

  task automatic do_in(input string tag, input logic ok, input int base, input int len,
                       input logic tog);
    int cnt;
    cnt = 0;
    txn_start(4'd0, 1'b1, 1'b0);
    check_val({tag, "_hs"}, handshake, HS_ACK);
    check_val({tag, "_tog"}, data_toggle, tog);
    for (int i = 0; i < MAX_PKT + 2; i++) begin
      if (!data_in_valid) break;
      check_val({tag, "_byte"}, data_in, rom[(base + i) % 256]);
      strobe();
      cnt++;
    end
    check_val({tag, "_len"}, cnt, len);
    txn_end(ok);
  endtask

  task automatic status_in(input string tag, input int new_addr);
    txn_start(4'd0, 1'b1, 1'b0);
    check_val({tag, "_sin_hs"}, handshake, HS_ACK);
    check_val({tag, "_sin_tog"}, data_toggle, 1);
    check_val({tag, "_sin_valid"}, data_in_valid, 0);
    check_val({tag, "_addr_pre"}, usb_address, exp_addr);
    txn_end(1'b1);
    exp_addr = new_addr;
    check_val({tag, "_addr_post"}, usb_address, exp_addr);
  endtask

  task automatic status_out(input string tag);
    txn_start(4'd0, 1'b0, 1'b0);
    check_val({tag, "_sout_hs"}, handshake, HS_ACK);
    check_val({tag, "_sout_tog"}, data_toggle, 1);
    txn_end(1'b1);
  endtask

  // Transfer-level model: outcome follows from the request fields alone.
  task automatic control(input string tag, input logic [7:0] req, input logic [15:0] wval,
                         input logic [15:0] wlen, input int retry_pct, input int early_at,
                         input bit ep2);
    int base, total, off, plen, pkt_no;
    logic tog;
    send_setup(mk_setup(req, wval, wlen), 8, 1'b1);
    if (ep2) begin
      do_hs({tag, "_ep2in"}, 4'd2, 1'b1, HS_NAK, 1'b1);
      do_hs({tag, "_ep2out"}, 4'd2, 1'b0, HS_NAK, 1'b1);
    end
    if (req == 8'h05) begin
      status_in(tag, int'(wval[6:0]));
    end else if (req == 8'h09) begin
      exp_cfg = int'(wval[7:0]);
      status_in(tag, exp_addr);
      check_val({tag, "_cfg"}, config_value, exp_cfg);
    end else if (req == 8'h06 && (wval[15:8] == 8'd1 || wval[15:8] == 8'd2)) begin
      base  = (wval[15:8] == 8'd1) ? DEV_BASE : CFG_BASE;
      total = (wval[15:8] == 8'd1) ? DEV_LEN : CFG_LEN;
      if (int'(wlen) < total) total = int'(wlen);
      off = 0; tog = 1'b1; pkt_no = 0;
      while (off < total) begin
        plen = (total - off < MAX_PKT) ? total - off : MAX_PKT;
        if ($urandom_range(0, 99) < retry_pct) do_in({tag, "_retry"}, 1'b0, base + off, plen, tog);
        if (pkt_no == early_at) begin
          do_hs({tag, "_early"}, 4'd0, 1'b0, HS_ACK, 1'b1);
          do_hs({tag, "_after_early"}, 4'd0, 1'b1, HS_NAK, 1'b0);
          return;
        end
        do_in({tag, "_in"}, 1'b1, base + off, plen, tog);
        off += plen; tog = ~tog; pkt_no++;
      end
      status_out(tag);
      do_hs({tag, "_idle"}, 4'd0, 1'b1, HS_NAK, 1'b0);
    end else begin
      do_hs({tag, "_stall_in"}, 4'd0, 1'b1, HS_STALL, 1'b0);
      do_hs({tag, "_stall_out"}, 4'd0, 1'b0, HS_STALL, 1'b0);
    end
  endtask

  initial begin
    int sel, r, early;
    logic [15:0] wl;
    logic [7:0] bad;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    tick(3);
    check_val("rst_hs", handshake, 0);
    check_val("rst_tog", data_toggle, 0);
    check_val("rst_data_in", data_in, 0);
    check_val("rst_valid", data_in_valid, 0);
    check_val("rst_addr", usb_address, 0);
    check_val("rst_cfg", config_value, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    tick(2);

    control("t1", 8'h05, 16'h0007, 16'd0, 0, -1, 1'b0);
    control("t2", 8'h06, 16'h0100, 16'd64, 0, -1, 1'b0);
    control("t3", 8'h06, 16'h0200, 16'd4, 100, -1, 1'b1);
    control("t4", 8'h0A, 16'h0000, 16'd0, 0, -1, 1'b0);
    control("t4b", 8'h09, 16'h0001, 16'd0, 0, -1, 1'b0);

    send_setup(mk_setup(8'h05, 16'h0033, 16'd0), 6, 1'b1);
    do_hs("t6_short", 4'd0, 1'b1, HS_NAK, 1'b0);
    check_val("t6_addr", usb_address, exp_addr);
    send_setup(mk_setup(8'h05, 16'h0033, 16'd0), 9, 1'b1);
    do_hs("t6_long", 4'd0, 1'b1, HS_NAK, 1'b0);
    do_hs("t6_ep2", 4'd2, 1'b0, HS_NAK, 1'b1);

    control("t5a", 8'h05, 16'h002A, 16'd0, 0, -1, 1'b0);
    send_setup(mk_setup(8'h06, 16'h0100, 16'd64), 8, 1'b1);
    do_in("t5_p1", 1'b1, DEV_BASE, MAX_PKT, 1'b1);
    txn_start(4'd0, 1'b1, 1'b0);
    strobe();
    strobe();
    check_val("t5_valid_pre", data_in_valid, 1);
    usb_rst = 1'b1;
    tick(1);
    exp_addr = 0; exp_cfg = 0;
    check_val("t5_valid", data_in_valid, 0);
    check_val("t5_addr", usb_address, exp_addr);
    check_val("t5_cfg", config_value, exp_cfg);
    check_val("t5_tog", data_toggle, 0);
    usb_rst = 1'b0;
    txn_end(1'b0);
    do_hs("t5_idle", 4'd0, 1'b1, HS_NAK, 1'b0);

    control("t5b", 8'h05, 16'h0015, 16'd0, 0, -1, 1'b0);
    txn_start(4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      data_out = 8'(i);
      strobe();
    end
    rst = 1'b1;
    #1;
    exp_addr = 0;
    check_val("t5_arst_addr", usb_address, exp_addr);
    check_val("t5_arst_valid", data_in_valid, 0);
    check_val("t5_arst_hs", handshake, 0);
    transaction_active = 1'b0; setup = 1'b0; data_strobe = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    do_hs("t5_arst_idle", 4'd0, 1'b1, HS_NAK, 1'b0);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 6);
      r = $urandom_range(0, 9);
      wl = (r == 0) ? 16'd0 : (r == 1) ? 16'hFFFF : 16'($urandom_range(1, 40));
      early = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      case (sel)
        0: control("r_addr", 8'h05, 16'($urandom_range(0, 65535)), 16'd0, 0, -1, 1'($urandom_range(0, 1)));
        1: control("r_cfg", 8'h09, 16'($urandom_range(0, 255)), 16'd0, 0, -1, 1'($urandom_range(0, 1)));
        2: control("r_dev", 8'h06, {8'h01, 8'($urandom_range(0, 255))}, wl, 30, early, 1'($urandom_range(0, 1)));
        3: control("r_cfgd", 8'h06, {8'h02, 8'($urandom_range(0, 255))}, wl, 30, early, 1'($urandom_range(0, 1)));
        4: control("r_baddesc", 8'h06, 16'h0300, wl, 0, -1, 1'b0);
        5: begin
          bad = 8'($urandom_range(0, 255));
          if (bad == 8'h05 || bad == 8'h06 || bad == 8'h09) bad = 8'h0A;
          control("r_badreq", bad, 16'h0000, wl, 0, -1, 1'b0);
        end
        default: begin
          r = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : 9;
          send_setup(mk_setup(8'h09, 16'h0005, 16'd0), r, 1'b1);
          do_hs("r_short", 4'd0, 1'b1, HS_NAK, 1'b0);
          check_val("r_short_cfg", config_value, exp_cfg);
        end
      endcase
    end
    check_val("final_addr", usb_address, exp_addr);
    check_val("final_cfg", config_value, exp_cfg);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
